// File: rtl/rti_pkg.sv
// Shared definitions for blocks that talk to the real-time input capture core.
package rti_pkg;

    localparam logic [4:0] RTI_ADDR_TLO   = 5'd0;
    localparam logic [4:0] RTI_ADDR_THI   = 5'd1;
    localparam logic [4:0] RTI_ADDR_EDGE  = 5'd2;
    localparam logic [4:0] RTI_ADDR_STAT  = 5'd3;
    localparam logic [4:0] RTI_ADDR_SHIFT = 5'd4;
    localparam logic [4:0] RTI_ADDR_FLUSH = 5'd5;

    localparam int STAT_EMPTY = 0;
    localparam int STAT_FULL  = 1;

    typedef struct packed {
        logic [31:0] upper;
        logic [31:0] lower;
        logic [31:0] edges;
    } rti_rec_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CMD_FLUSH = 3'd1,
        ST_CMD_SHIFT = 3'd2,
        ST_POLL      = 3'd3,
        ST_RD_LO     = 3'd4,
        ST_RD_HI     = 3'd5,
        ST_RD_EDGE   = 3'd6,
        ST_OUT       = 3'd7
    } rti_drain_state_t;

endpackage

// File: rtl/rti_drain.sv
// Drain engine for the RTI capture FIFO: polls status, reads one edge record,
// pops it and presents it on a valid/ready stream; also issues flush and
// shift-start commands.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | no bus cycle; pick flush > shift > poll
// CMD_FLUSH | write strobe to the flush register
// CMD_SHIFT | write strobe to the shift-start register
// POLL      | read status; count full, go idle on empty
// RD_LO     | read lower timer word
// RD_HI     | read upper timer word
// RD_EDGE   | read edge word, single read pulse pops the FIFO head
// OUT       | hold record on the stream until accepted
import rti_pkg::*;

module rti_drain #(
    parameter int POLL_GAP   = 2,
    parameter int FULL_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  trig,
    input  logic                  flush_req,
    output logic                  cs,
    output logic                  read,
    output logic                  write,
    output logic [4:0]            addr,
    output logic [31:0]           wr_data,
    input  logic [31:0]           rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [95:0]           m_data,
    output logic [FULL_CNT_W-1:0] overflow_cnt,
    output logic                  busy
);

    localparam logic [2:0] S_IDLE      = ST_IDLE;
    localparam logic [2:0] S_CMD_FLUSH = ST_CMD_FLUSH;
    localparam logic [2:0] S_CMD_SHIFT = ST_CMD_SHIFT;
    localparam logic [2:0] S_POLL      = ST_POLL;
    localparam logic [2:0] S_RD_LO     = ST_RD_LO;
    localparam logic [2:0] S_RD_HI     = ST_RD_HI;
    localparam logic [2:0] S_RD_EDGE   = ST_RD_EDGE;
    localparam logic [2:0] S_OUT       = ST_OUT;

    localparam int GAP_W = $clog2(POLL_GAP + 2);

    logic [2:0]            state;
    logic [2:0]            state_nxt;
    logic                  flush_pend;
    logic                  trig_pend;
    logic [GAP_W-1:0]      gap_cnt;
    logic                  gap_tc;
    rti_rec_t              rec;

    // The gap counter is loaded after an empty poll; the poll is allowed in
    // the idle cycle where it reaches its last count, so POLL_GAP idle cycles
    // separate consecutive empty polls.
    assign gap_tc  = (gap_cnt <= GAP_W'(1));
    assign busy    = (state != S_IDLE) || flush_pend || trig_pend;
    assign m_data  = rec;
    assign wr_data = 32'h0;

    // Next-state selection
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (flush_pend)
                    state_nxt = S_CMD_FLUSH;
                else if (trig_pend)
                    state_nxt = S_CMD_SHIFT;
                else if (enable && gap_tc)
                    state_nxt = S_POLL;
            end
            S_CMD_FLUSH: state_nxt = S_IDLE;
            S_CMD_SHIFT: state_nxt = S_IDLE;
            S_POLL:      state_nxt = rd_data[STAT_EMPTY] ? S_IDLE : S_RD_LO;
            S_RD_LO:     state_nxt = S_RD_HI;
            S_RD_HI:     state_nxt = S_RD_EDGE;
            S_RD_EDGE:   state_nxt = S_OUT;
            S_OUT:       state_nxt = m_ready ? S_IDLE : S_OUT;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // State register and bus outputs registered from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            cs      <= 1'b0;
            read    <= 1'b0;
            write   <= 1'b0;
            addr    <= 5'd0;
            m_valid <= 1'b0;
        end else begin
            state   <= state_nxt;
            cs      <= 1'b0;
            read    <= 1'b0;
            write   <= 1'b0;
            addr    <= 5'd0;
            m_valid <= 1'b0;
            case (state_nxt)
                S_CMD_FLUSH: begin cs <= 1'b1; write <= 1'b1; addr <= RTI_ADDR_FLUSH; end
                S_CMD_SHIFT: begin cs <= 1'b1; write <= 1'b1; addr <= RTI_ADDR_SHIFT; end
                S_POLL:      begin cs <= 1'b1; addr <= RTI_ADDR_STAT; end
                S_RD_LO:     begin cs <= 1'b1; addr <= RTI_ADDR_TLO; end
                S_RD_HI:     begin cs <= 1'b1; addr <= RTI_ADDR_THI; end
                S_RD_EDGE:   begin cs <= 1'b1; read <= 1'b1; addr <= RTI_ADDR_EDGE; end
                S_OUT:       m_valid <= 1'b1;
                default:     ;
            endcase
        end
    end

    // Sticky command requests; a new pulse during the issue cycle stays pending
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush_pend <= 1'b0;
            trig_pend  <= 1'b0;
        end else begin
            flush_pend <= (flush_pend && (state != S_CMD_FLUSH)) || flush_req;
            trig_pend  <= (trig_pend && (state != S_CMD_SHIFT)) || trig;
        end
    end

    // Poll spacing down-counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            gap_cnt <= '0;
        else if ((state == S_POLL) && rd_data[STAT_EMPTY])
            gap_cnt <= GAP_W'(POLL_GAP);
        else if (gap_cnt != '0)
            gap_cnt <= gap_cnt - GAP_W'(1);
    end

    // Saturating count of polls that saw the FIFO full
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            overflow_cnt <= '0;
        else if ((state == S_POLL) && rd_data[STAT_FULL] && (overflow_cnt != '1))
            overflow_cnt <= overflow_cnt + {{(FULL_CNT_W-1){1'b0}}, 1'b1};
    end

    // Record capture; rd_data is taken at the edge closing each read state
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rec <= '0;
        else begin
            case (state)
                S_RD_LO:   rec.lower <= rd_data;
                S_RD_HI:   rec.upper <= rd_data;
                S_RD_EDGE: rec.edges <= rd_data;
                default:   ;
            endcase
        end
    end

endmodule

// File: tb/tb_rti_drain.sv
module tb_rti_drain;
    import rti_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        trig = 1'b0;
    logic        flush_req = 1'b0;
    logic        m_ready = 1'b0;
    logic        cs, read, write, m_valid, busy;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data = 32'h0;
    logic [95:0] m_data;
    logic [15:0] overflow_cnt;

    logic        enable2 = 1'b0;
    logic        cs2, read2, write2, m_valid2, busy2;
    logic [4:0]  addr2;
    logic [31:0] wr_data2, rd_data2;
    logic [95:0] m_data2;
    logic [1:0]  overflow_cnt2;

    rti_drain #(.POLL_GAP(2), .FULL_CNT_W(16)) dut (
        .clk(clk), .reset(reset), .enable(enable), .trig(trig), .flush_req(flush_req),
        .cs(cs), .read(read), .write(write), .addr(addr), .wr_data(wr_data),
        .rd_data(rd_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .overflow_cnt(overflow_cnt), .busy(busy)
    );

    // Second instance: narrow overflow counter against an always empty+full RTI
    rti_drain #(.POLL_GAP(2), .FULL_CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .enable(enable2), .trig(1'b0), .flush_req(1'b0),
        .cs(cs2), .read(read2), .write(write2), .addr(addr2), .wr_data(wr_data2),
        .rd_data(rd_data2), .m_valid(m_valid2), .m_ready(1'b1), .m_data(m_data2),
        .overflow_cnt(overflow_cnt2), .busy(busy2)
    );
    assign rd_data2 = (addr2 == RTI_ADDR_STAT) ? 32'h3 : 32'h0;

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_read = 0, n_cs = 0, n_poll = 0, n_acc = 0, n_poll2 = 0;
    int last_poll_cyc = 0, acc_cyc = 0;
    int poll_cyc_q[$];
    int wr_addr_q[$];
    int wr_cyc_q[$];
    rti_rec_t fifo[$];
    rti_rec_t exp_q[$];
    rti_rec_t exp_rec;
    logic force_full = 1'b0;
    bit pend_pop = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // RTI model (show-ahead FIFO, rd_data mux) plus bus monitor and scoreboard
    always @(negedge clk) begin
        if (pend_pop) begin
            if (fifo.size() > 0) void'(fifo.pop_front());
            pend_pop = 1'b0;
        end
        if (read) begin
            n_read++;
            pend_pop = 1'b1;
            total++;
            if (!(cs && !write && addr == RTI_ADDR_EDGE)) begin
                bad++;
                $display("FAIL read_qual: cs=%0b write=%0b addr=%0d, need cs=1 write=0 addr=2", cs, write, addr);
            end
        end
        if (cs) n_cs++;
        if (cs && !write && addr == RTI_ADDR_STAT) begin
            n_poll++;
            last_poll_cyc = cyc;
            poll_cyc_q.push_back(cyc);
        end
        if (write) begin
            wr_addr_q.push_back(int'(addr));
            wr_cyc_q.push_back(cyc);
            total++;
            if (wr_data !== 32'h0) begin
                bad++;
                $display("FAIL wr_data: got %0h want 0", wr_data);
            end
        end
        if (m_valid && m_ready) begin
            n_acc++;
            acc_cyc = cyc;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_extra: got record %h, none expected", m_data);
            end else begin
                exp_rec = exp_q.pop_front();
                if (m_data !== exp_rec) begin
                    bad++;
                    $display("FAIL sb_data: got %h want %h", m_data, exp_rec);
                end
            end
        end
        if (cs2 && addr2 == RTI_ADDR_STAT) n_poll2++;
        case (addr)
            RTI_ADDR_TLO:  rd_data = (fifo.size() > 0) ? fifo[0].lower : 32'h0;
            RTI_ADDR_THI:  rd_data = (fifo.size() > 0) ? fifo[0].upper : 32'h0;
            RTI_ADDR_EDGE: rd_data = (fifo.size() > 0) ? fifo[0].edges : 32'h0;
            RTI_ADDR_STAT: rd_data = {30'h0, force_full, fifo.size() == 0};
            default:       rd_data = 32'h0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rec(input rti_rec_t r);
        fifo.push_back(r);
        exp_q.push_back(r);
    endtask

    function automatic rti_rec_t rand_rec();
        rti_rec_t r;
        r.upper = $urandom;
        r.lower = $urandom;
        r.edges = $urandom;
        return r;
    endfunction

    task automatic test_reset();
        int cs0;
        reset = 1'b1;
        repeat (5) tick();
        total++;
        if ({cs, read, write, addr, m_valid, busy} !== 10'b0) begin
            bad++;
            $display("FAIL reset_ctl: cs=%0b rd=%0b wr=%0b addr=%0d mv=%0b busy=%0b, need all 0", cs, read, write, addr, m_valid, busy);
        end
        total++;
        if (overflow_cnt !== 16'h0 || overflow_cnt2 !== 2'h0) begin
            bad++;
            $display("FAIL reset_ovf: got %0d/%0d want 0/0", overflow_cnt, overflow_cnt2);
        end
        total++;
        if (m_data !== 96'h0 || wr_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_data: m_data=%h wr_data=%h want 0", m_data, wr_data);
        end
        reset = 1'b0;
        cs0 = n_cs;
        repeat (10) tick();
        total++;
        if (n_cs != cs0 || n_read != 0) begin
            bad++;
            $display("FAIL disabled_bus: cs cycles=%0d reads=%0d want 0/0", n_cs - cs0, n_read);
        end
    endtask

    task automatic test_single();
        rti_rec_t r;
        bit got = 1'b0;
        int r0 = n_read;
        r.upper = 32'h1; r.lower = 32'h23456789; r.edges = 32'hA;
        push_rec(r);
        m_ready = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            if (m_valid) got = 1'b1;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL single_timeout: m_valid=0 want 1");
        end else begin
            total++;
            if (m_data !== 96'h00000001_23456789_0000000A) begin
                bad++;
                $display("FAIL single_data: got %h want 00000001234567890000000a", m_data);
            end
            total++;
            if (cyc - last_poll_cyc != 4) begin
                bad++;
                $display("FAIL single_latency: got %0d want 4", cyc - last_poll_cyc);
            end
        end
        enable = 1'b0;
        for (int i = 0; i < 50 && busy; i++) tick();
        total++;
        if (busy || n_read - r0 != 1) begin
            bad++;
            $display("FAIL single_reads: busy=%0b reads=%0d want 0/1", busy, n_read - r0);
        end
    endtask

    task automatic test_ready_stall();
        bit got = 1'b0;
        int r0 = n_read;
        int a0 = n_acc;
        int cs0;
        logic [95:0] snap;
        push_rec(rand_rec());
        push_rec(rand_rec());
        m_ready = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            if (m_valid) got = 1'b1;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL stall_timeout: m_valid=0 want 1");
        end
        snap = m_data;
        cs0 = n_cs;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (m_valid !== 1'b1 || m_data !== snap) begin
                bad++;
                $display("FAIL stall_hold: mv=%0b data=%h want 1/%h", m_valid, m_data, snap);
            end
        end
        total++;
        if (n_cs != cs0) begin
            bad++;
            $display("FAIL stall_bus: cs cycles=%0d want 0", n_cs - cs0);
        end
        m_ready = 1'b1;
        for (int i = 0; i < 60 && n_acc < a0 + 2; i++) tick();
        enable = 1'b0;
        for (int i = 0; i < 50 && busy; i++) tick();
        total++;
        if (n_acc - a0 != 2 || n_read - r0 != 2) begin
            bad++;
            $display("FAIL stall_count: accepted=%0d reads=%0d want 2/2", n_acc - a0, n_read - r0);
        end
    endtask

    task automatic test_empty_polls();
        int p0;
        int r0 = n_read;
        poll_cyc_q.delete();
        enable = 1'b1;
        for (int i = 0; i < 60 && poll_cyc_q.size() < 5; i++) tick();
        total++;
        if (poll_cyc_q.size() < 5) begin
            bad++;
            $display("FAIL poll_timeout: polls=%0d want 5", poll_cyc_q.size());
        end else begin
            for (int i = 1; i < 5; i++) begin
                total++;
                if (poll_cyc_q[i] - poll_cyc_q[i-1] != 3) begin
                    bad++;
                    $display("FAIL poll_gap: got %0d want 3", poll_cyc_q[i] - poll_cyc_q[i-1]);
                end
            end
        end
        force_full = 1'b1;
        p0 = n_poll;
        for (int i = 0; i < 60 && n_poll < p0 + 3; i++) tick();
        force_full = 1'b0;
        tick();
        total++;
        if (overflow_cnt !== 16'd3) begin
            bad++;
            $display("FAIL overflow_cnt: got %0d want 3", overflow_cnt);
        end
        enable = 1'b0;
        for (int i = 0; i < 50 && busy; i++) tick();
        total++;
        if (n_read != r0) begin
            bad++;
            $display("FAIL empty_reads: got %0d want 0", n_read - r0);
        end
    endtask

    task automatic test_saturate();
        int p0 = n_poll2;
        enable2 = 1'b1;
        for (int i = 0; i < 40 && n_poll2 < p0 + 2; i++) tick();
        total++;
        if (overflow_cnt2 !== 2'd2) begin
            bad++;
            $display("FAIL sat_two: got %0d want 2", overflow_cnt2);
        end
        for (int i = 0; i < 40 && n_poll2 < p0 + 5; i++) tick();
        total++;
        if (overflow_cnt2 !== 2'd3 || n_poll2 < p0 + 5) begin
            bad++;
            $display("FAIL sat_five: got %0d after %0d polls want 3 after 5", overflow_cnt2, n_poll2 - p0);
        end
        enable2 = 1'b0;
    endtask

    task automatic test_cmd_collide();
        bit got = 1'b0;
        int a0 = n_acc;
        push_rec(rand_rec());
        wr_addr_q.delete();
        wr_cyc_q.delete();
        m_ready = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            if (cs && addr == RTI_ADDR_THI) got = 1'b1;
        end
        flush_req = 1'b1;
        trig = 1'b1;
        tick();
        flush_req = 1'b0;
        trig = 1'b0;
        enable = 1'b0;
        for (int i = 0; i < 50 && busy; i++) tick();
        total++;
        if (!got || n_acc - a0 != 1 || busy) begin
            bad++;
            $display("FAIL cmd_drain: saw_rd_hi=%0b accepted=%0d busy=%0b want 1/1/0", got, n_acc - a0, busy);
        end
        total++;
        if (wr_addr_q.size() != 2) begin
            bad++;
            $display("FAIL cmd_count: got %0d write cycles want 2", wr_addr_q.size());
        end else begin
            total++;
            if (wr_addr_q[0] != 5 || wr_addr_q[1] != 4) begin
                bad++;
                $display("FAIL cmd_order: got %0d,%0d want 5,4", wr_addr_q[0], wr_addr_q[1]);
            end
            total++;
            if (wr_cyc_q[0] != acc_cyc + 2 || wr_cyc_q[1] != acc_cyc + 4) begin
                bad++;
                $display("FAIL cmd_timing: got +%0d,+%0d want +2,+4", wr_cyc_q[0] - acc_cyc, wr_cyc_q[1] - acc_cyc);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit got = 1'b0;
        int r0;
        int a0 = n_acc;
        push_rec(rand_rec());
        m_ready = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            if (cs && addr == RTI_ADDR_THI) got = 1'b1;
        end
        reset = 1'b1;
        #1;
        total++;
        if (m_valid !== 1'b0 || read !== 1'b0 || cs !== 1'b0 || !got) begin
            bad++;
            $display("FAIL rst_mid: mv=%0b rd=%0b cs=%0b saw_rd_hi=%0b want 0/0/0/1", m_valid, read, cs, got);
        end
        r0 = n_read;
        repeat (3) tick();
        reset = 1'b0;
        total++;
        if (n_read != r0) begin
            bad++;
            $display("FAIL rst_read: got %0d reads during reset want 0", n_read - r0);
        end
        for (int i = 0; i < 60 && n_acc < a0 + 1; i++) tick();
        enable = 1'b0;
        for (int i = 0; i < 50 && busy; i++) tick();
        total++;
        if (n_acc - a0 != 1 || n_read - r0 != 1 || fifo.size() != 0) begin
            bad++;
            $display("FAIL rst_redrain: accepted=%0d reads=%0d left=%0d want 1/1/0", n_acc - a0, n_read - r0, fifo.size());
        end
    endtask

    task automatic test_random_stream();
        int r0 = n_read;
        int a0 = n_acc;
        int n = 8;
        for (int i = 0; i < n; i++) push_rec(rand_rec());
        enable = 1'b1;
        for (int i = 0; i < 600 && n_acc < a0 + n; i++) begin
            tick();
            m_ready = 1'($urandom_range(0, 1));
        end
        m_ready = 1'b1;
        enable = 1'b0;
        for (int i = 0; i < 50 && busy; i++) tick();
        total++;
        if (n_acc - a0 != n || n_read - r0 != n || exp_q.size() != 0) begin
            bad++;
            $display("FAIL random_stream: accepted=%0d reads=%0d pending=%0d want %0d/%0d/0", n_acc - a0, n_read - r0, exp_q.size(), n, n);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_ready_stall();
        test_empty_polls();
        test_saturate();
        test_cmd_collide();
        test_reset_mid();
        test_random_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
